uart_alu_cmd_tx: RTL
====================

Name: uart_alu_cmd_tx

Overview:
Synthesizable UART command transmitter that serialises one complete UART-ALU command packet (header plus N operands) onto a TX line. It is the parametrised, self-checking stimulus source for the uart_alu top-level in simulation and on hardware loopback builds. It is generalised in operand count, operand width, baud and frame format. It adds a packet-level handshake that the plain clock/reset harness does not provide.

Parameters:
ClkFreqHz, 100_000_000, input clock frequency in Hz
BaudRate, 115_200, UART bit rate; ClksPerBit = ClkFreqHz/BaudRate (integer division, must be >= 2)
MaxOperands, 8, maximum operands per packet (>= 1)
OperandWidth, 32, bits per operand; must be a multiple of 8
ParityEn, 0, 1 inserts a parity bit after the data bits
ParityOdd, 0, 1 = odd parity, 0 = even parity (ignored when ParityEn = 0)
StopBits, 1, number of stop bits: 1 or 2

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  block idle, accepts a command
opcode_i  in  8  opcode byte
num_ops_i  in  $clog2(MaxOperands+1)  operand count
operands_i  in  MaxOperands*OperandWidth  operand k occupies bits [k*OperandWidth +: OperandWidth]
tx_o  out  1  UART serial out, idle high
busy_o  out  1  packet in progress
done_o  out  1  one-cycle pulse when packet completes

Behaviour:
- Interface: one clock, clk_i. Reset rst_ni is synchronous and active-low.
- Reset values: tx_o=1, cmd_ready_o=1, busy_o=0, done_o=0. Internal counters are cleared.
- Handshake: a command is accepted on a rising edge with cmd_valid_i && cmd_ready_o. All inputs are captured into registers at that edge and later input changes are ignored. cmd_ready_o is 0 from the next cycle until done_o is asserted.
- Packet byte order:
  - byte 0: opcode
  - byte 1: 0x00 (reserved)
  - byte 2: LEN[7:0]
  - byte 3: LEN[15:8]
  - then operands 0..N-1, each little-endian (LSB byte first)
- LEN = 4 + N*OperandWidth/8, computed as a 16-bit value.
- Clamping: N = min(num_ops_i, MaxOperands). N = 0 sends the 4-byte header only.
- Frame format, one frame per byte:
  - start bit (0)
  - 8 data bits, LSB first
  - optional parity: XOR of the data, inverted when ParityOdd
  - StopBits stop bits (1)
- Bit timing: each bit lasts exactly ClksPerBit cycles. tx_o goes low the cycle after acceptance. Consecutive bytes are back-to-back with no idle gap between the last stop bit and the next start bit.
- Top FSM states: IDLE, LOAD, SEND, DONE.
  - IDLE -> LOAD on accept.
  - LOAD takes 1 cycle to select the next byte. It is hidden inside the start bit, so tx_o is already low during LOAD.
  - SEND -> LOAD when a byte finishes and more bytes remain.
  - SEND -> DONE after the final stop bit.
  - DONE lasts 1 cycle: done_o=1, busy_o=0, cmd_ready_o=1, then the FSM returns to IDLE.
- Back-to-back commands: a command offered during DONE is accepted. Its start bit follows the previous stop bit after exactly one cycle of tx_o=1.
- busy_o is 1 from the cycle after acceptance through the last stop-bit cycle.
- Packet duration: ClksPerBit*(10+ParityEn+StopBits-1)*LEN cycles from the first start-bit cycle to the end of the last stop bit.
- Reset mid-packet: at the next edge with rst_ni=0 all outputs return to their reset values and the partial frame is abandoned. No done_o is emitted.
- Counter widths: the baud counter is $clog2(ClksPerBit) bits and wraps at ClksPerBit-1. The byte index is wide enough for 4+MaxOperands*OperandWidth/8.

Decomposition:
- uart_alu_pkg holds:
  - opcode constants: OpEcho=8'hEC, OpAdd=8'hAD, OpMul=8'h88, OpDiv=8'hD1
  - HeaderBytes=4
  - an enum for the top FSM states
- Sub-module uart_tx_byte is a single-byte serialiser:
  - inputs: byte + start strobe
  - outputs: tx and frame_done
  - it owns the baud counter, bit counter and parity
  - parameters: ClksPerBit, ParityEn, ParityOdd, StopBits
- The top level owns the packet FSM, the byte mux and the LEN computation.

Test Plan:
- ClkFreqHz=1000, BaudRate=100, opcode=0xEC, num_ops=0 -> 4 frames 0xEC,0x00,0x04,0x00; 400 cycles of tx activity; one done_o pulse; cmd_ready_o high after it.
- OpAdd, N=2, operands 0x11223344 and 0xAABBCCDD -> bytes AD 00 0C 00 44 33 22 11 DD CC BB AA; every bit lasts exactly 10 cycles.
- ParityEn=1, ParityOdd=1, StopBits=2, opcode 0x88 -> frame 0,0001_0001,1(odd),1,1; frame length 12 bits = 120 cycles.
- num_ops_i=MaxOperands+3 -> packet clamps to MaxOperands operands; LEN=4+4*MaxOperands.
- Second command held valid through DONE -> accepted that cycle; exactly one idle-high cycle between packets; operand inputs changed mid-packet do not corrupt the data.
- rst_ni low for one cycle during operand byte 5 -> tx_o=1, busy_o=0, cmd_ready_o=1 at the next edge; no done_o; the following packet is transmitted correctly.

Source files
------------

// File: rtl/uart_alu_pkg.sv
// Shared constants and types for the UART-ALU command transmitter.
package uart_alu_pkg;

  localparam logic [7:0] OpEcho = 8'hEC;
  localparam logic [7:0] OpAdd  = 8'hAD;
  localparam logic [7:0] OpMul  = 8'h88;
  localparam logic [7:0] OpDiv  = 8'hD1;

  localparam int unsigned HeaderBytes = 4;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSend,
    StDone
  } pkt_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART serialiser: start, 8 data bits LSB first, optional parity, stop bits.
module uart_tx_byte #(
  parameter int unsigned ClksPerBit = 868,
  parameter bit          ParityEn   = 1'b0,
  parameter bit          ParityOdd  = 1'b0,
  parameter int unsigned StopBits   = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  output logic       tx_o,
  output logic       frame_done_o
);

  localparam int unsigned CntW      = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int unsigned FrameBits = 9 + int'(ParityEn) + StopBits;
  localparam logic [CntW-1:0] BaudMax   = CntW'(ClksPerBit - 1);
  localparam logic [3:0]      LastBit   = 4'(FrameBits - 1);
  localparam logic [3:0]      ParityBit = 4'd9;

  logic            active_q, active_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [3:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            parity_q, parity_d;

  assign frame_done_o = active_q && (baud_q == BaudMax) && (bit_q == LastBit);

  always_comb begin
    active_d = active_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    parity_d = parity_q;
    if (start_i) begin
      // The strobe arrives one cycle into the start bit, so the baud count starts at 1.
      active_d = 1'b1;
      baud_d   = CntW'(1);
      bit_d    = 4'd0;
      shreg_d  = byte_i;
      parity_d = (^byte_i) ^ ParityOdd;
    end else if (active_q) begin
      if (baud_q == BaudMax) begin
        baud_d = '0;
        if (bit_q == LastBit) begin
          active_d = 1'b0;
        end else begin
          bit_d = bit_q + 4'd1;
          if (bit_q != 4'd0 && bit_q <= 4'd8) begin
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end
      end else begin
        baud_d = baud_q + CntW'(1);
      end
    end
  end

  always_comb begin
    tx_o = 1'b1;
    if (active_q) begin
      if (bit_q == 4'd0) begin
        tx_o = 1'b0;
      end else if (bit_q <= 4'd8) begin
        tx_o = shreg_q[0];
      end else if (ParityEn && bit_q == ParityBit) begin
        tx_o = parity_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= 4'd0;
      shreg_q  <= 8'h00;
      parity_q <= 1'b0;
    end else begin
      active_q <= active_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      parity_q <= parity_d;
    end
  end

endmodule

// File: rtl/uart_alu_cmd_tx.sv
// Serialises one UART-ALU command packet (header plus operands) with a packet handshake.
module uart_alu_cmd_tx
  import uart_alu_pkg::*;
#(
  parameter int unsigned ClkFreqHz    = 100_000_000,
  parameter int unsigned BaudRate     = 115_200,
  parameter int unsigned MaxOperands  = 8,
  parameter int unsigned OperandWidth = 32,
  parameter bit          ParityEn     = 1'b0,
  parameter bit          ParityOdd    = 1'b0,
  parameter int unsigned StopBits     = 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  cmd_valid_i,
  output logic                                  cmd_ready_o,
  input  logic [7:0]                            opcode_i,
  input  logic [$clog2(MaxOperands+1)-1:0]      num_ops_i,
  input  logic [MaxOperands*OperandWidth-1:0]   operands_i,
  output logic                                  tx_o,
  output logic                                  busy_o,
  output logic                                  done_o
);

  localparam int unsigned ClksPerBit = ClkFreqHz / BaudRate;
  localparam int unsigned BytesPerOp = OperandWidth / 8;
  localparam int unsigned MaxBytes   = HeaderBytes + MaxOperands * BytesPerOp;
  localparam int unsigned IdxW       = $clog2(MaxBytes);
  localparam int unsigned OpsW       = MaxOperands * OperandWidth;

  pkt_state_e      state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [7:0]      opcode_q, opcode_d;
  logic [15:0]     len_q, len_d;
  logic [OpsW-1:0] ops_q, ops_d;

  int unsigned     n_eff;
  logic [15:0]     len_new;
  logic [IdxW-1:0] last_new;
  logic            ser_start;
  logic [7:0]      ser_byte;
  logic            ser_tx;
  logic            frame_done;

  always_comb begin
    n_eff = 32'(num_ops_i);
    if (n_eff > MaxOperands) begin
      n_eff = MaxOperands;
    end
    len_new  = 16'(HeaderBytes + n_eff * BytesPerOp);
    last_new = IdxW'(HeaderBytes + n_eff * BytesPerOp - 1);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    opcode_d    = opcode_q;
    len_d       = len_q;
    ops_d       = ops_q;
    cmd_ready_o = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    ser_start   = 1'b0;
    ser_byte    = 8'h00;

    unique case (state_q)
      StIdle: begin
        cmd_ready_o = 1'b1;
      end
      StLoad: begin
        busy_o    = 1'b1;
        ser_start = 1'b1;
        state_d   = StSend;
        if (idx_q == IdxW'(0)) begin
          ser_byte = opcode_q;
        end else if (idx_q == IdxW'(1)) begin
          ser_byte = 8'h00;
        end else if (idx_q == IdxW'(2)) begin
          ser_byte = len_q[7:0];
        end else if (idx_q == IdxW'(3)) begin
          ser_byte = len_q[15:8];
        end else begin
          ser_byte = ops_q[7:0];
        end
      end
      StSend: begin
        busy_o = 1'b1;
        if (frame_done) begin
          if (idx_q == last_q) begin
            state_d = StDone;
          end else begin
            state_d = StLoad;
            idx_d   = idx_q + IdxW'(1);
            // Operand bytes go out LSB first, so the capture register shifts down a byte.
            if (idx_q >= IdxW'(HeaderBytes)) begin
              ops_d = {8'h00, ops_q[OpsW-1:8]};
            end
          end
        end
      end
      StDone: begin
        cmd_ready_o = 1'b1;
        done_o      = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (cmd_ready_o && cmd_valid_i) begin
      state_d  = StLoad;
      idx_d    = '0;
      last_d   = last_new;
      opcode_d = opcode_i;
      len_d    = len_new;
      ops_d    = operands_i;
    end
  end

  // LOAD is the first cycle of the start bit, before the serialiser has the byte.
  assign tx_o = (state_q == StLoad) ? 1'b0 : ser_tx;

  uart_tx_byte #(
    .ClksPerBit (ClksPerBit),
    .ParityEn   (ParityEn),
    .ParityOdd  (ParityOdd),
    .StopBits   (StopBits)
  ) u_tx_byte (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (ser_start),
    .byte_i       (ser_byte),
    .tx_o         (ser_tx),
    .frame_done_o (frame_done)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      last_q   <= '0;
      opcode_q <= 8'h00;
      len_q    <= 16'h0000;
      ops_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      opcode_q <= opcode_d;
      len_q    <= len_d;
      ops_q    <= ops_d;
    end
  end

endmodule
